// File: rtl/backing_ram.sv
// backing_ram: word-addressed backing memory answering cache misses with a fixed-latency block burst
module backing_ram #(
    parameter int RAM_ADDRESS_BITS = 10,
    parameter int DATA_WIDTH       = 32,
    parameter int BLOCK_BITS       = 2,
    parameter int LATENCY          = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        miss,
    input  logic [RAM_ADDRESS_BITS-1:0] prop_address,
    input  logic [DATA_WIDTH-1:0]       prop_write_data,
    input  logic                        prop_write_en,
    output logic [DATA_WIDTH-1:0]       fill_data,
    output logic                        fill_valid,
    output logic [BLOCK_BITS-1:0]       fill_word,
    output logic                        fill_last,
    output logic                        busy
);
    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
    localparam int CW = $clog2(LATENCY + 1);
    localparam int NW = RAM_ADDRESS_BITS - BLOCK_BITS;
    state_t                        state;
    logic [DATA_WIDTH-1:0]         mem [2**RAM_ADDRESS_BITS];
    logic [NW-1:0]                 blk;
    logic [BLOCK_BITS-1:0]         idx;
    logic [CW-1:0]                 cnt;
    logic [RAM_ADDRESS_BITS-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]         rd_data;
    logic                          ready;
    // The fill_last cycle counts as idle so a held miss restarts with zero bubble
    assign ready   = (state == IDLE) || (state == BURST && fill_last);
    assign rd_addr = {blk, idx};
    assign rd_data = (prop_write_en && prop_address == rd_addr) ? prop_write_data : mem[rd_addr];
    // Write-through port; contents survive reset but reset-cycle writes are dropped
    always_ff @(posedge clk) begin
        if (!reset && prop_write_en) mem[prop_address] <= prop_write_data;
    end
    // Request FSM with registered burst outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            blk        <= '0;
            idx        <= '0;
            cnt        <= '0;
            fill_data  <= '0;
            fill_valid <= 1'b0;
            fill_word  <= '0;
            fill_last  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            fill_data  <= '0;
            fill_valid <= 1'b0;
            fill_word  <= '0;
            fill_last  <= 1'b0;
            if (ready) begin
                if (miss) begin
                    blk   <= prop_address[RAM_ADDRESS_BITS-1:BLOCK_BITS];
                    idx   <= '0;
                    cnt   <= CW'(LATENCY - 1);
                    state <= (LATENCY == 1) ? BURST : WAIT;
                    busy  <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else if (state == WAIT) begin
                cnt   <= cnt - 1'b1;
                state <= (cnt == CW'(1)) ? BURST : WAIT;
            end else begin
                fill_data  <= rd_data;
                fill_valid <= 1'b1;
                fill_word  <= idx;
                fill_last  <= &idx;
                idx        <= idx + 1'b1;
            end
        end
    end
endmodule

// File: doc/backing_ram.md
# backing_ram

Word-addressed backing memory serving a single direct-connected cache as the memory-side responder. It accepts the cache's write-through stream (`prop_address`/`prop_write_data`/`prop_write_en`) every cycle and answers a `miss` request with a fixed-latency burst of one full cache block. The block sits between the cache and the top level and replaces the ideal RAM model in cache simulations.

## Interface
- `RAM_ADDRESS_BITS`, 10, word address width; array depth 2^RAM_ADDRESS_BITS
- `DATA_WIDTH`, 32, word width
- `BLOCK_BITS`, 2, log2 of words per cache block; burst length 2^BLOCK_BITS
- `LATENCY`, 4, cycles from miss acceptance to first fill word; legal range ≥1
- `clk`  in  1  clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `miss`  in  1  level fill request from the cache
- `prop_address`  in  RAM_ADDRESS_BITS  write address; also the miss address when `miss` is high
- `prop_write_data`  in  DATA_WIDTH  write data
- `prop_write_en`  in  1  write strobe, one word per cycle
- `fill_data`  out  DATA_WIDTH  burst word, registered
- `fill_valid`  out  1  `fill_data` valid this cycle
- `fill_word`  out  BLOCK_BITS  offset of the current word within its block
- `fill_last`  out  1  final burst word
- `busy`  out  1  a request is in progress

## Operation
- Array: 2^RAM_ADDRESS_BITS × DATA_WIDTH. Contents are not cleared by reset.
- Writes: when `prop_write_en` is high at an edge and `reset` is low, the array is written. Writes are accepted in every state, including during a burst.
- FSM states:
  - IDLE: if `miss` is high, latch base = `prop_address` with its low BLOCK_BITS bits cleared, load the wait counter with LATENCY-1, and go to WAIT. If LATENCY = 1, go directly to BURST.
  - WAIT: decrement the counter; at 0, go to BURST.
  - BURST: output words base+0 … base+2^BLOCK_BITS-1 in ascending order, one per cycle. After the last word, return to IDLE.
- Word order is always from offset 0; there is no critical-word-first ordering.
- The base address is held for the whole request. Address arithmetic is within the block only, so there is no carry out of the block; block 2^RAM_ADDRESS_BITS-4 … max is legal.
- `miss` is sampled only in IDLE. `miss` high in WAIT or BURST is ignored. `miss` still high in the first IDLE cycle after `fill_last` starts a new request. The cache must drop `miss` in its `fill_last` cycle.
- Write/read hazard: if the word being loaded into `fill_data` at an edge is written at the same edge, `fill_data` takes `prop_write_data` (write-first forwarding). Writes at earlier edges are visible through the array.
- Simultaneous `miss` and `prop_write_en` in IDLE: both are performed. If the write hits the requested block, the fill returns the new data.
- `busy` = state ≠ IDLE.

## Timing
- Reset values (cycle after an edge with `reset` high): state IDLE, `fill_valid`=0, `fill_last`=0, `busy`=0, `fill_data`=0, `fill_word`=0, counter=0.
- Reset mid-request abandons the burst with no partial words afterwards. A write presented in a reset cycle is dropped.
- `miss` accepted at edge E: `busy`=1 from E. The first `fill_valid` appears after edge E+LATENCY, with word n following edge E+LATENCY+n.
- `fill_last`=1 with `fill_valid` on word 2^BLOCK_BITS-1 only. `busy` falls at the following edge.
- Earliest next acceptance is at the edge ending the `fill_last` cycle, giving back-to-back requests with zero bubble.
- `fill_data`/`fill_word` are 0 whenever `fill_valid`=0.

## Test plan
- Reset held 2 cycles, with `miss`=1 and `prop_write_en`=1 (addr 5, 0xAA) → all outputs 0, `busy`=0. A later miss on addr 5 does not return 0xAA.
- Write 0x55 to addr 10; `miss` with `prop_address`=9 at edge E (LATENCY=4) → `fill_valid` after E+4..E+7 with `fill_word` 0,1,2,3. Word 2 = 0x55; `fill_last` only on word 3.
- During the above burst, write 0x77 to addr 11 at the edge that loads word 3 → `fill_data`=0x77 on word 3. Write 0x99 to addr 8 during the burst → word 0 unaffected; a later miss returns 0x99.
- `miss` held high continuously for addr 0 then addr 4 (address changed in the `fill_last` cycle) → second burst accepted at the edge ending `fill_last`. It returns words 4..7, and `miss` during WAIT/BURST causes no extra request.
- `reset` asserted for one cycle after word 1 of a burst → no further `fill_valid`, `busy`=0 next cycle. A new miss then behaves normally.
- Miss on addr 1023 → words 1020..1023, `fill_word` 0..3, no wrap into block 0. Check with LATENCY=1: first word immediately after the accept edge.
